phy_rst_seq: RTL



---
 rtl/phy_rst_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/phy_rst_seq.sv
// PHY hardware-reset sequencer: minimum-width reset pulse, settle wait, then ready.
// Optional completed-sequence counter on rst_count is built when PHY_RST_CNT_EN is defined.
module phy_rst_seq #(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned ASSERT_CYCLES = 1250000,
    parameter int unsigned SETTLE_CYCLES = 6250000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rstn_phy_req,
    input  logic       soft_rst,
    output logic       phy_rstn,
    output logic       phy_ready,
    output logic       busy,
    output logic       seq_done,
    output logic [7:0] rst_count
);

    localparam int unsigned ST_W    = 4;
    localparam int unsigned RCNT_W  = 8;

    localparam logic [3:0] ST_HOLD   = 4'b0001;
    localparam logic [3:0] ST_ASSERT = 4'b0010;
    localparam logic [3:0] ST_SETTLE = 4'b0100;
    localparam logic [3:0] ST_READY  = 4'b1000;

    // Terminal counts; both parameters are at least 1 so the subtraction never underflows.
    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic phy_rstn_nxt;
    logic phy_ready_nxt;
    logic busy_nxt;
    logic seq_done_nxt;

    // State, interval counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            phy_rstn  <= 1'b0;
            phy_ready <= 1'b0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            phy_rstn  <= phy_rstn_nxt;
            phy_ready <= phy_ready_nxt;
            busy      <= busy_nxt;
            seq_done  <= seq_done_nxt;
        end
    end

    // Next state and output decode; a dropped request overrides everything but rst
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;

        if (!rstn_phy_req) begin
            state_nxt = ST_HOLD;
        end else begin
            case (state)
                ST_HOLD: begin
                    state_nxt = ST_ASSERT;
                end
                ST_ASSERT: begin
                    // soft_rst is ignored here so the pulse is never stretched
                    if (cnt == ASSERT_LAST) begin
                        state_nxt = ST_SETTLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (soft_rst) begin
                        state_nxt = ST_ASSERT;
                    end else if (cnt == SETTLE_LAST) begin
                        state_nxt = ST_READY;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (soft_rst) begin
                        state_nxt = ST_ASSERT;
                    end
                end
                default: begin
                    state_nxt = ST_HOLD;
                end
            endcase
        end

        phy_rstn_nxt  = (state_nxt == ST_SETTLE) || (state_nxt == ST_READY);
        phy_ready_nxt = (state_nxt == ST_READY);
        busy_nxt      = (state_nxt == ST_ASSERT) || (state_nxt == ST_SETTLE);
        seq_done_nxt  = (state_nxt == ST_READY) && (state != ST_READY);
    end

`ifdef PHY_RST_CNT_EN
    logic [RCNT_W-1:0] rst_count_q;

    // Saturating count of completed sequences, cleared only by rst
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rst_count_q <= '0;
        end else if (seq_done_nxt && (rst_count_q != {RCNT_W{1'b1}})) begin
            rst_count_q <= rst_count_q + RCNT_W'(1);
        end
    end

    assign rst_count = rst_count_q;
`else
    assign rst_count = RCNT_W'(0);
`endif

endmodule
